// File: rtl/if_fetch.sv
// Instruction fetch stage: reads one 32-bit instruction as four little-endian
// byte reads and hands it, with its PC, to the IF/ID latch.
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_flag_in,
    input  logic [5:0]        stall_in,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_valid_i,
    input  logic [7:0]        mem_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              stall_req_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [INST_W-1:0] buffer;
    logic [INST_W-1:0] buffer_fill;
    logic              byte_accept;

    // Only the IF/ID stall bit matters to this stage.
    logic unused_stall;
    assign unused_stall = &{1'b0, stall_in[5:2], stall_in[0]};

    // A returned byte counts only while requesting and not being flushed.
    assign byte_accept = (state == FETCH) && mem_valid_i && !branch_flag_in;

    always_comb begin
        buffer_fill = buffer;
        buffer_fill[{cnt, 3'b000} +: 8] = mem_data_i;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (!branch_flag_in) state_next = FETCH;
            FETCH: begin
                if (branch_flag_in)
                    state_next = IDLE;
                else if (mem_valid_i && cnt == 2'd3)
                    state_next = DONE;
            end
            DONE:  if (branch_flag_in || !stall_in[1]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register here resets asynchronously and updates with <= only.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt       <= 2'd0;
            fetch_pc  <= '0;
            buffer    <= '0;
            inst_o    <= '0;
            inst_pc_o <= '0;
        end else if (rdy_in) begin
            if (state == IDLE && !branch_flag_in) begin
                fetch_pc <= pc_in;
                cnt      <= 2'd0;
                buffer   <= '0;
            end else if (byte_accept) begin
                buffer <= buffer_fill;
                cnt    <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    inst_o    <= buffer_fill;
                    inst_pc_o <= fetch_pc;
                end
            end
        end
    end

    // The counter supplies the low address bits, so the PC's own [1:0] are dropped.
    assign mem_addr_o   = {fetch_pc[ADDR_W-1:2], cnt};
    assign mem_req_o    = (state == FETCH);
    assign inst_valid_o = (state == DONE);
    assign stall_req_o  = (state != DONE);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: zero-wait and wait-state fetches, stall hold,
// flush, global-ready freeze and asynchronous reset.
module tb_if_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] pc_in;
    logic        branch_flag_in;
    logic [5:0]  stall_in;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i;
    logic [7:0]  mem_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stall_req_o;

    int checks   = 0;
    int failures = 0;

    if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .pc_in          (pc_in),
        .branch_flag_in (branch_flag_in),
        .stall_in       (stall_in),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_valid_i    (mem_valid_i),
        .mem_data_i     (mem_data_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_valid_o   (inst_valid_o),
        .stall_req_o    (stall_req_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One byte from the memory model, preceded by `waits` idle cycles.
    task automatic fetch_byte(input logic [31:0] addr, input logic [7:0] data, input int waits);
        mem_valid_i = 1'b0;
        for (int w = 0; w < waits; w++) begin
            check("wait_req", {31'd0, mem_req_o}, 32'd1);
            check("wait_addr", mem_addr_o, addr);
            check("wait_valid", {31'd0, inst_valid_o}, 32'd0);
            step();
        end
        mem_valid_i = 1'b1;
        mem_data_i  = data;
        check("byte_req", {31'd0, mem_req_o}, 32'd1);
        check("byte_addr", mem_addr_o, addr);
        check("byte_stall_req", {31'd0, stall_req_o}, 32'd1);
        step();
        mem_valid_i = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [31:0] inst, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
        check({tag, "_inst"}, inst_o, inst);
        check({tag, "_pc"}, inst_pc_o, pc);
        check({tag, "_stall_req"}, {31'd0, stall_req_o}, 32'd0);
        check({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
        check({tag, "_stall_req"}, {31'd0, stall_req_o}, 32'd1);
    endtask

    initial begin
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        pc_in          = 32'h0;
        branch_flag_in = 1'b0;
        stall_in       = 6'd0;
        mem_valid_i    = 1'b0;
        mem_data_i     = 8'h00;

        // Reset state
        #3;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_inst_pc", inst_pc_o, 32'h0);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        #9 rst_in = 1'b0;

        // Zero-wait fetch at 0x0: valid in cycle 6
        check_idle("t1_idle");
        step();
        fetch_byte(32'h0, 8'h13, 0);
        fetch_byte(32'h1, 8'h05, 0);
        fetch_byte(32'h2, 8'h10, 0);
        fetch_byte(32'h3, 8'h00, 0);
        check_done("t1_done", 32'h0010_0513, 32'h0);
        step();

        // Fetch at 0x104 with two wait cycles per byte: valid in cycle 14
        check_idle("t2_idle");
        pc_in = 32'h104;
        step();
        fetch_byte(32'h104, 8'h11, 2);
        fetch_byte(32'h105, 8'h22, 2);
        fetch_byte(32'h106, 8'h33, 2);
        fetch_byte(32'h107, 8'h44, 2);
        check_done("t2_done", 32'h4433_2211, 32'h104);

        // Held in DONE while IF/ID is stalled
        stall_in = 6'b000010;
        pc_in    = 32'h20;
        for (int i = 0; i < 3; i++) begin
            step();
            check_done("t3_hold", 32'h4433_2211, 32'h104);
        end
        stall_in = 6'd0;
        step();
        check_idle("t3_release");

        // Flush after two bytes of a fetch at 0x20; flush beats a returned byte
        step();
        fetch_byte(32'h20, 8'haa, 0);
        fetch_byte(32'h21, 8'hbb, 0);
        check("t4_addr_before_flush", mem_addr_o, 32'h22);
        branch_flag_in = 1'b1;
        mem_valid_i    = 1'b1;
        mem_data_i     = 8'hcc;
        pc_in          = 32'h80;
        step();
        check_idle("t4_flushed");
        branch_flag_in = 1'b0;
        mem_valid_i    = 1'b0;
        step();
        fetch_byte(32'h80, 8'h01, 0);
        fetch_byte(32'h81, 8'h02, 0);
        fetch_byte(32'h82, 8'h03, 0);
        fetch_byte(32'h83, 8'h04, 0);
        check_done("t4_done", 32'h0403_0201, 32'h80);
        step();

        // Global ready low for four cycles with a byte pulsed mid-fetch
        pc_in = 32'h200;
        step();
        fetch_byte(32'h200, 8'h78, 0);
        rdy_in      = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = 8'hff;
        for (int i = 0; i < 4; i++) begin
            check("t5_frozen_addr", mem_addr_o, 32'h201);
            check("t5_frozen_req", {31'd0, mem_req_o}, 32'd1);
            step();
        end
        rdy_in      = 1'b1;
        mem_valid_i = 1'b0;
        fetch_byte(32'h201, 8'h56, 0);
        fetch_byte(32'h202, 8'h34, 0);
        fetch_byte(32'h203, 8'h12, 0);
        check_done("t5_done", 32'h1234_5678, 32'h200);
        step();

        // Asynchronous reset between edges mid-fetch
        pc_in = 32'h300;
        step();
        fetch_byte(32'h300, 8'h9a, 0);
        check("t6_addr_pre_reset", mem_addr_o, 32'h301);
        #2 rst_in = 1'b1;
        #1;
        check("t6_req", {31'd0, mem_req_o}, 32'd0);
        check("t6_addr", mem_addr_o, 32'h0);
        check("t6_inst", inst_o, 32'h0);
        check("t6_inst_pc", inst_pc_o, 32'h0);
        check("t6_valid", {31'd0, inst_valid_o}, 32'd0);
        check("t6_stall_req", {31'd0, stall_req_o}, 32'd1);
        #1 rst_in = 1'b0;
        step();
        check("t6_restart_req", {31'd0, mem_req_o}, 32'd1);
        check("t6_restart_addr", mem_addr_o, 32'h300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
